// File: rtl/ccu_cmd_feeder.sv
// ccu_cmd_feeder: buffers host bytes and replays complete CCU packets as gapless bursts; CCU_FEEDER_ERRCNT_EN adds err_count
module ccu_cmd_feeder #(
    parameter int DEPTH = 16,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       ccu_busy,
    output logic [7:0] cmd,
    output logic       cmd_strobe,
    output logic       pkt_done,
    output logic       err_pulse
`ifdef CCU_FEEDER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP + 2);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_HOLD} state_t;
    state_t state_q, state_d;
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic [2:0] len_q, len_d, left_q, left_d, head_len;
    logic [GW-1:0] hold_q, hold_d;
    logic [7:0] cmd_q, cmd_d, head;
    logic strobe_q, strobe_d, done_q, done_d, err_q, err_d, push, pop;
    assign head       = mem_q[rd_q];
    assign head_len   = (head == 8'h4C || head == 8'h52) ? 3'd5 :
                        (head == 8'h50) ? 3'd3 :
                        (head == 8'h43) ? 3'd1 : 3'd0;
    assign host_ready = !rst && (count_q < CW'(DEPTH));
    assign push       = host_valid && host_ready;
    assign count_d    = count_q + CW'(push) - CW'(pop);
    assign cmd        = cmd_q;
    assign cmd_strobe = strobe_q;
    assign pkt_done   = done_q;
    assign err_pulse  = err_q;
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        left_d   = left_q;
        hold_d   = hold_q;
        cmd_d    = 8'h00;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        pop      = 1'b0;
        case (state_q)
            S_IDLE:
                if (count_q != '0) begin
                    if (head_len != 3'd0) begin
                        len_d   = head_len;
                        state_d = S_WAIT;
                    end else begin
                        pop   = 1'b1;
                        err_d = head != 8'h00;
                    end
                end
            // The opcode is launched from WAIT so it reaches cmd two cycles after lookup.
            S_WAIT:
                if (count_q > CW'(len_q) && !ccu_busy) begin
                    pop      = 1'b1;
                    cmd_d    = head;
                    strobe_d = 1'b1;
                    left_d   = len_q;
                    state_d  = S_ISSUE;
                end
            S_ISSUE:
                if (left_q != 3'd0) begin
                    pop      = 1'b1;
                    cmd_d    = head;
                    strobe_d = 1'b1;
                    done_d   = left_q == 3'd1;
                    left_d   = left_q - 3'd1;
                end else begin
                    hold_d  = GW'(1);
                    state_d = S_HOLD;
                end
            S_HOLD:
                if (hold_q >= GW'(GAP) && !ccu_busy) state_d = S_IDLE;
                else if (hold_q < GW'(GAP)) hold_d = hold_q + GW'(1);
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            len_q    <= '0;
            left_q   <= '0;
            hold_q   <= '0;
            cmd_q    <= 8'h00;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            left_q   <= left_d;
            hold_q   <= hold_d;
            cmd_q    <= cmd_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= host_data;
    end
`ifdef CCU_FEEDER_ERRCNT_EN
    logic [7:0] errcnt_q;
    always_ff @(posedge clk) begin
        if (rst) errcnt_q <= 8'h00;
        else if (err_d && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
    end
    assign err_count = errcnt_q;
`endif
endmodule

// File: tb/tb_ccu_cmd_feeder.sv
// tb_ccu_cmd_feeder: directed bench for ccu_cmd_feeder bursts, gating, errors, backpressure and reset
module tb_ccu_cmd_feeder;
    localparam int GAP = 2;
    logic clk = 1'b0, rst = 1'b1, host_valid = 1'b0, ccu_busy = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic host_ready, cmd_strobe, pkt_done, err_pulse;
    logic [7:0] cmd;
`ifdef CCU_FEEDER_ERRCNT_EN
    logic [7:0] err_count;
`endif
    int errors = 0, checks = 0, cyc = 0, errs = 0;
    typedef struct {logic [7:0] d; int c; logic done;} ent_t;
    ent_t lg[$];
    ent_t e;

    ccu_cmd_feeder dut (
        .clk(clk), .rst(rst), .host_data(host_data), .host_valid(host_valid),
        .host_ready(host_ready), .ccu_busy(ccu_busy), .cmd(cmd),
        .cmd_strobe(cmd_strobe), .pkt_done(pkt_done), .err_pulse(err_pulse)
`ifdef CCU_FEEDER_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cmd_strobe === 1'b1) begin
            e.d = cmd;
            e.c = cyc;
            e.done = pkt_done;
            lg.push_back(e);
        end
        if (err_pulse === 1'b1) errs++;
    end

    task step();
        @(posedge clk);
        #1;
    endtask

    task put(input logic [7:0] b);
        host_valid = 1'b1;
        host_data = b;
        step();
        host_valid = 1'b0;
    endtask

    task idle(input int n);
        host_valid = 1'b0;
        repeat (n) step();
    endtask

    task test_reset();
        rst = 1'b1;
        host_valid = 1'b1;
        host_data = 8'h4C;
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 3;
            if (host_ready !== 1'b0) begin errors++; $display("FAIL reset_ready%0d: got %b expected 0", i, host_ready); end
            if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd%0d: got %h expected 00", i, cmd); end
            if (cmd_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe%0d: got %b expected 0", i, cmd_strobe); end
        end
        rst = 1'b0;
        host_valid = 1'b0;
        #1;
        checks++;
        if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", host_ready); end
        idle(6);
        checks += 2;
        if (lg.size() != 0) begin errors++; $display("FAIL reset_no_burst: got %0d bytes expected 0", lg.size()); end
        if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_pulse); end
    endtask

    task test_line();
        logic [7:0] v [6];
        v = '{8'h4C, 8'h00, 8'h00, 8'h32, 8'h1E, 8'h0A};
        lg.delete();
        for (int i = 0; i < 6; i++) put(v[i]);
        idle(12);
        checks++;
        if (lg.size() != 6) begin errors++; $display("FAIL line_len: got %0d expected 6", lg.size()); end
        for (int i = 0; i < 6 && i < lg.size(); i++) begin
            checks += 3;
            if (lg[i].d !== v[i]) begin errors++; $display("FAIL line_byte%0d: got %h expected %h", i, lg[i].d, v[i]); end
            if (lg[i].c != lg[0].c + i) begin errors++; $display("FAIL line_gapless%0d: got cycle %0d expected %0d", i, lg[i].c, lg[0].c + i); end
            if (lg[i].done !== (i == 5)) begin errors++; $display("FAIL line_done%0d: got %b expected %b", i, lg[i].done, i == 5); end
        end
        checks += 2;
        if (cmd !== 8'h00) begin errors++; $display("FAIL line_nop_after: got %h expected 00", cmd); end
        if (cmd_strobe !== 1'b0) begin errors++; $display("FAIL line_strobe_after: got %b expected 0", cmd_strobe); end
    endtask

    task test_partial();
        logic [7:0] v [4];
        v = '{8'h50, 8'h05, 8'h07, 8'h03};
        lg.delete();
        for (int i = 0; i < 3; i++) put(v[i]);
        idle(10);
        checks++;
        if (lg.size() != 0) begin errors++; $display("FAIL partial_held: got %0d bytes expected 0", lg.size()); end
        put(v[3]);
        idle(10);
        checks++;
        if (lg.size() != 4) begin errors++; $display("FAIL partial_len: got %0d expected 4", lg.size()); end
        for (int i = 0; i < 4 && i < lg.size(); i++) begin
            checks += 2;
            if (lg[i].d !== v[i]) begin errors++; $display("FAIL partial_byte%0d: got %h expected %h", i, lg[i].d, v[i]); end
            if (lg[i].c != lg[0].c + i) begin errors++; $display("FAIL partial_gapless%0d: got cycle %0d expected %0d", i, lg[i].c, lg[0].c + i); end
        end
    endtask

    task test_back_to_back();
        int fall_cyc;
        lg.delete();
        put(8'h43);
        put(8'h11);
        put(8'h43);
        put(8'h22);
        ccu_busy = 1'b1;
        idle(8);
        checks++;
        if (lg.size() != 2) begin errors++; $display("FAIL busy_block: got %0d bytes expected 2", lg.size()); end
        ccu_busy = 1'b0;
        fall_cyc = cyc;
        idle(10);
        checks++;
        if (lg.size() != 4) begin errors++; $display("FAIL busy_len: got %0d expected 4", lg.size()); end
        if (lg.size() == 4) begin
            checks += 5;
            if (lg[1].d !== 8'h11) begin errors++; $display("FAIL busy_first_arg: got %h expected 11", lg[1].d); end
            if (lg[2].d !== 8'h43) begin errors++; $display("FAIL busy_second_op: got %h expected 43", lg[2].d); end
            if (lg[2].c != fall_cyc + 3) begin errors++; $display("FAIL busy_release: got cycle %0d expected %0d", lg[2].c, fall_cyc + 3); end
            if (lg[2].c - lg[1].c < GAP + 2) begin errors++; $display("FAIL busy_gap: got %0d expected >= %0d", lg[2].c - lg[1].c, GAP + 2); end
            if (lg[3].d !== 8'h22 || lg[3].done !== 1'b1) begin errors++; $display("FAIL busy_second_arg: got %h/%b expected 22/1", lg[3].d, lg[3].done); end
        end
    endtask

    task test_unknown();
        lg.delete();
        errs = 0;
        put(8'h99);
        put(8'h43);
        put(8'h05);
        idle(10);
        checks += 2;
        if (errs != 1) begin errors++; $display("FAIL unk_err_pulses: got %0d expected 1", errs); end
        if (lg.size() != 2) begin errors++; $display("FAIL unk_len: got %0d expected 2", lg.size()); end
        if (lg.size() == 2) begin
            checks++;
            if (lg[0].d !== 8'h43 || lg[1].d !== 8'h05) begin errors++; $display("FAIL unk_burst: got %h %h expected 43 05", lg[0].d, lg[1].d); end
        end
`ifdef CCU_FEEDER_ERRCNT_EN
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL unk_err_count: got %0d expected 1", err_count); end
`endif
    endtask

    task test_full();
        lg.delete();
        ccu_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            host_valid = 1'b1;
            host_data = (i % 2 == 1) ? 8'((i + 1) / 2) : 8'h43;
            checks++;
            if (host_ready !== 1'(i < 16)) begin errors++; $display("FAIL full_ready%0d: got %b expected %b", i, host_ready, i < 16); end
            step();
        end
        host_valid = 1'b0;
        checks++;
        if (lg.size() != 0) begin errors++; $display("FAIL full_blocked: got %0d bytes expected 0", lg.size()); end
        ccu_busy = 1'b0;
        idle(100);
        checks++;
        if (lg.size() != 16) begin errors++; $display("FAIL full_drain_len: got %0d expected 16", lg.size()); end
        if (lg.size() == 16) begin
            checks++;
            if (lg[14].d !== 8'h43 || lg[15].d !== 8'h08) begin errors++; $display("FAIL full_last_pkt: got %h %h expected 43 08", lg[14].d, lg[15].d); end
        end
    endtask

    task test_reset_mid();
        logic [7:0] v [4];
        logic found;
        v = '{8'h50, 8'h01, 8'h02, 8'h03};
        lg.delete();
        errs = 0;
        found = 1'b0;
        put(8'h52); put(8'h0A); put(8'h0B); put(8'h0C); put(8'h0D); put(8'h0E);
        for (int i = 0; i < 20; i++) begin
            if (cmd_strobe === 1'b1 && cmd === 8'h0B) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rmid_timeout: got no third byte expected 0b within 20 cycles"); end
        rst = 1'b1;
        step();
        checks += 4;
        if (cmd !== 8'h00) begin errors++; $display("FAIL rmid_cmd: got %h expected 00", cmd); end
        if (cmd_strobe !== 1'b0) begin errors++; $display("FAIL rmid_strobe: got %b expected 0", cmd_strobe); end
        if (pkt_done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b expected 0", pkt_done); end
        if (host_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %b expected 0", host_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (host_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b expected 1", host_ready); end
        idle(10);
        checks += 2;
        if (lg.size() != 3) begin errors++; $display("FAIL rmid_aborted: got %0d bytes expected 3", lg.size()); end
        if (errs != 0) begin errors++; $display("FAIL rmid_flushed: got %0d err pulses expected 0", errs); end
`ifdef CCU_FEEDER_ERRCNT_EN
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL rmid_err_count: got %0d expected 0", err_count); end
`endif
        lg.delete();
        for (int i = 0; i < 4; i++) put(v[i]);
        idle(12);
        checks++;
        if (lg.size() != 4) begin errors++; $display("FAIL rmid_pixel_len: got %0d expected 4", lg.size()); end
        for (int i = 0; i < 4 && i < lg.size(); i++) begin
            checks += 2;
            if (lg[i].d !== v[i]) begin errors++; $display("FAIL rmid_pixel%0d: got %h expected %h", i, lg[i].d, v[i]); end
            if (lg[i].done !== (i == 3)) begin errors++; $display("FAIL rmid_pixel_done%0d: got %b expected %b", i, lg[i].done, i == 3); end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_partial();
        test_back_to_back();
        test_unknown();
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ccu_cmd_feeder.md
Name: ccu_cmd_feeder

Overview:
- Upstream stage of the command control unit.
- Buffers host command bytes in a FIFO and checks each opcode against a fixed length table.
- Replays each complete packet (opcode plus arguments) as a gapless burst on the 8-bit command input of the CCU, one byte per clock.
- Between packets, drives NOP and waits for the CCU to finish before starting the next packet.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, minimum 8.
- GAP, 2, minimum NOP cycles driven after the last byte of a packet before the next opcode.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- host_data  input  8  command/argument byte from host.
- host_valid  input  1  host_data valid this cycle.
- host_ready  output  1  FIFO can accept a byte; a transfer occurs when host_valid and host_ready are both high.
- ccu_busy  input  1  CCU is executing a packet; high blocks the next packet.
- cmd  output  8  registered byte to the CCU cmd input; 0x00 (NOP) when idle.
- cmd_strobe  output  1  high in every cycle cmd carries packet data (opcode or argument).
- pkt_done  output  1  one-cycle pulse with the last byte of each packet.
- err_pulse  output  1  one-cycle pulse when an unknown opcode is discarded.

Behaviour:
- Reset values: host_ready=0 during rst and 1 the cycle after; cmd=0x00, cmd_strobe=0, pkt_done=0, err_pulse=0; FIFO empty; state IDLE.
- Opcode table (number of argument bytes):
  - 0x00 NOP: 0; popped silently, nothing emitted.
  - 0x4C LINE: 5 (Xs, Ys, Xe, Ye, color).
  - 0x52 RECT: 5 (Xs, Ys, Xe, Ye, color).
  - 0x50 PIXEL: 3 (X, Y, color).
  - 0x43 CLEAR: 1 (color).
  - Any other value is unknown.
- FIFO and host handshake:
  - Occupancy count is log2(DEPTH)+1 bits wide.
  - host_ready = (count < DEPTH), derived from the registered count, so a full FIFO never accepts a byte.
  - Push and pop in the same cycle leave count unchanged.
- State machine:
  - IDLE: if FIFO non-empty, look up the head byte.
    - NOP: pop it, stay in IDLE.
    - Unknown: pop it, pulse err_pulse next cycle, stay in IDLE.
    - Known: go to WAIT.
  - WAIT: when count >= len+1 and ccu_busy==0, go to ISSUE. Partial packets are never started.
  - ISSUE: pop one byte per cycle into cmd with cmd_strobe=1, for exactly len+1 consecutive cycles. No bubbles; ccu_busy is ignored once the burst has begun. pkt_done is high alongside the last byte. Then go to HOLD.
  - HOLD: cmd=0x00, cmd_strobe=0 for at least GAP cycles, then until ccu_busy==0, then back to IDLE.
- Latency: a complete packet already in the FIFO with ccu_busy=0 puts its opcode on cmd 2 cycles after the head byte is first visible in IDLE.
- Back-to-back packets are separated by at least GAP+1 NOP cycles.
- Host writes during ISSUE are accepted if space remains. The packet in flight is unaffected.
- If DEPTH is smaller than a packet, that packet can never issue. DEPTH >= 8 guarantees every table entry fits.
- rst asserted mid-packet: FIFO flushed, burst aborted, all outputs return to reset values the following cycle. No partial-packet completion.

Optional Feature:
- Macro: CCU_FEEDER_ERRCNT_EN.
- Defined: adds output err_count[7:0].
  - Saturating count of discarded unknown opcodes: stops at 0xFF, cleared by rst.
  - Increments in the same cycle as err_pulse.
- Not defined: port absent, no counter logic. err_pulse behaviour is identical in both builds.

Test Plan:
- Reset: hold rst 3 cycles with host_valid=1 and data 0x4C -> nothing accepted; cmd=0x00, cmd_strobe=0 throughout; host_ready=1 one cycle after rst drops.
- Single LINE: write 4C,00,00,32,1E,0A with ccu_busy=0 -> cmd shows 4C,00,00,32,1E,0A on 6 consecutive cycles with cmd_strobe=1; pkt_done only with 0A; then cmd=0x00.
- Partial packet: write 50,05,07 and pause 10 cycles -> cmd_strobe stays 0. Write 03 -> burst 50,05,07,03 follows.
- Busy gating: two CLEAR packets 43,11 and 43,22 with ccu_busy held high 8 cycles after the first -> second opcode appears only after ccu_busy falls, and no earlier than GAP+1 cycles after byte 11.
- Unknown opcode plus full FIFO: write 99 then 43,05 -> one err_pulse (err_count=1 when the macro is defined), then burst 43,05. Separately, hold ccu_busy=1 and write 20 bytes -> host_ready low after 16; bytes 17-20 not accepted.
- Reset mid-burst: assert rst on the 3rd byte of a RECT burst -> next cycle cmd=0x00, cmd_strobe=0, FIFO empty; a new PIXEL packet after reset issues normally.
